px_stream_arbiter: RTL and testbench

//  Shares one top_gray_sobel pixel datapath between two pulse-handshake pixel sources: requester 0 (SPI

---
 rtl/px_stream_arbiter_pkg.sv | 17 +
 rtl/px_stream_arbiter_if.sv | 28 ++
 rtl/px_stream_arbiter_tag_fifo.sv | 52 +++++
 rtl/px_stream_arbiter.sv | 119 +++++++++++
 tb/tb_px_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/px_stream_arbiter_pkg.sv
// Shared constants and types for the pixel stream arbiter: pixel width, mode encodings
// and the source identifier stored in the tag FIFO.
package px_stream_arbiter_pkg;

    localparam int MAX_PIXEL_BITS = 24;

    localparam logic [1:0] ARB_MODE_REQ0 = 2'b00;
    localparam logic [1:0] ARB_MODE_REQ1 = 2'b01;
    localparam logic [1:0] ARB_MODE_RR   = 2'b10;
    localparam logic [1:0] ARB_MODE_PRIO = 2'b11;

    typedef enum logic {
        SRC_SPI  = 1'b0,
        SRC_LFSR = 1'b1
    } src_e;

endpackage

// File: rtl/px_stream_arbiter_if.sv
// Pixel buses around the arbiter: two requester streams and the shared datapath.
// Every stream is a pulse handshake: data is valid only in the single cycle its rdy strobe is high.
interface px_stream_arbiter_if #(
    parameter int PX_W = 24
);
    logic [PX_W-1:0] s0_px_i;
    logic            s0_rdy_i;
    logic [PX_W-1:0] s0_px_o;
    logic            s0_rdy_o;
    logic [PX_W-1:0] s1_px_i;
    logic            s1_rdy_i;
    logic [PX_W-1:0] s1_px_o;
    logic            s1_rdy_o;
    logic [PX_W-1:0] dp_px_o;
    logic            dp_rdy_o;
    logic [PX_W-1:0] dp_px_i;
    logic            dp_rdy_i;

    modport slave (
        input  s0_px_i, s0_rdy_i, s1_px_i, s1_rdy_i, dp_px_i, dp_rdy_i,
        output s0_px_o, s0_rdy_o, s1_px_o, s1_rdy_o, dp_px_o, dp_rdy_o
    );

    modport master (
        output s0_px_i, s0_rdy_i, s1_px_i, s1_rdy_i, dp_px_i, dp_rdy_i,
        input  s0_px_o, s0_rdy_o, s1_px_o, s1_rdy_o, dp_px_o, dp_rdy_o
    );
endinterface

// File: rtl/px_stream_arbiter_tag_fifo.sv
// In-order record of which source issued each pixel still inside the datapath.
// Pointers wrap naturally because DEPTH is a power of two.
module px_tag_fifo
    import px_stream_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic flush_i,
    input  logic push_i,
    input  src_e push_tag_i,
    input  logic pop_i,
    output src_e head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    src_e          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= SRC_SPI;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= push_tag_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_i) rd_ptr <= rd_ptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/px_stream_arbiter.sv
// Shares one pixel datapath between two pulse-handshake sources: one holding register per source,
// mode-selected grant, and in-order routing of datapath results back to the issuing source.
module px_stream_arbiter
    import px_stream_arbiter_pkg::*;
#(
    parameter int PX_W      = MAX_PIXEL_BITS,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                nreset_i,
    input  logic [1:0]          mode_i,
    input  logic                enable_i,
    input  logic                flush_i,
    px_stream_arbiter_if.slave  bus,
    output logic [1:0]          overflow_o,
    output logic                spurious_o,
    output logic                busy_o
);
    logic [PX_W-1:0] hold [2];
    logic [PX_W-1:0] px_in [2];
    logic [1:0]      valid;
    logic [1:0]      rdy_in;
    logic [1:0]      elig;
    logic [1:0]      grant;
    src_e            last_grant;
    src_e            head_tag;
    logic            tag_full;
    logic            tag_empty;
    logic            pop;

    logic [PX_W-1:0] dp_px_q, s0_px_q, s1_px_q;
    logic            dp_rdy_q, s0_rdy_q, s1_rdy_q;

    assign px_in[0]  = bus.s0_px_i;
    assign px_in[1]  = bus.s1_px_i;
    assign rdy_in    = {bus.s1_rdy_i, bus.s0_rdy_i};

    assign bus.dp_px_o  = dp_px_q;
    assign bus.dp_rdy_o = dp_rdy_q;
    assign bus.s0_px_o  = s0_px_q;
    assign bus.s0_rdy_o = s0_rdy_q;
    assign bus.s1_px_o  = s1_px_q;
    assign bus.s1_rdy_o = s1_rdy_q;

    assign busy_o = (|valid) || !tag_empty;
    assign pop    = bus.dp_rdy_i && !tag_empty && !flush_i;

    // Full comes from the registered count, so a same-cycle pop never unblocks a grant.
    always_comb begin
        elig[0] = valid[0] && (mode_i != ARB_MODE_REQ1);
        elig[1] = valid[1] && (mode_i != ARB_MODE_REQ0);
        grant   = 2'b00;
        if (enable_i && !flush_i && !tag_full) begin
            if (elig[0] && elig[1]) begin
                if (mode_i == ARB_MODE_RR && last_grant == SRC_SPI) grant = 2'b10;
                else                                                 grant = 2'b01;
            end else if (elig[0]) begin
                grant = 2'b01;
            end else if (elig[1]) begin
                grant = 2'b10;
            end
        end
    end

    px_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .flush_i    (flush_i),
        .push_i     (|grant),
        .push_tag_i (grant[1] ? SRC_LFSR : SRC_SPI),
        .pop_i      (pop),
        .head_o     (head_tag),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            hold[0]    <= '0;
            hold[1]    <= '0;
            valid      <= '0;
            last_grant <= SRC_LFSR;
            dp_px_q    <= '0;
            dp_rdy_q   <= 1'b0;
            s0_px_q    <= '0;
            s0_rdy_q   <= 1'b0;
            s1_px_q    <= '0;
            s1_rdy_q   <= 1'b0;
            overflow_o <= '0;
            spurious_o <= 1'b0;
        end else begin
            dp_rdy_q <= |grant;
            if (|grant) begin
                dp_px_q    <= grant[1] ? hold[1] : hold[0];
                last_grant <= grant[1] ? SRC_LFSR : SRC_SPI;
            end
            // A strobe landing in the cycle its own hold is granted refills the slot.
            for (int n = 0; n < 2; n++) begin
                if (flush_i) begin
                    valid[n] <= 1'b0;
                end else if (rdy_in[n]) begin
                    if (valid[n] && !grant[n]) begin
                        overflow_o[n] <= 1'b1;
                    end else begin
                        hold[n]  <= px_in[n];
                        valid[n] <= 1'b1;
                    end
                end else if (grant[n]) begin
                    valid[n] <= 1'b0;
                end
            end
            s0_rdy_q <= pop && (head_tag == SRC_SPI);
            s1_rdy_q <= pop && (head_tag == SRC_LFSR);
            if (pop && head_tag == SRC_SPI)  s0_px_q <= bus.dp_px_i;
            if (pop && head_tag == SRC_LFSR) s1_px_q <= bus.dp_px_i;
            if (bus.dp_rdy_i && tag_empty) spurious_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_px_stream_arbiter.sv
// Directed bench for px_stream_arbiter: hand-computed grant order, return routing,
// overflow/spurious flags, backpressure, flush and asynchronous reset.
module tb_px_stream_arbiter;
    import px_stream_arbiter_pkg::*;

    localparam int PX_W = MAX_PIXEL_BITS;

    logic       clk = 1'b0;
    logic       nreset_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic       enable_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [1:0] overflow_o;
    logic       spurious_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;

    px_stream_arbiter_if #(.PX_W(PX_W)) bus ();

    px_stream_arbiter #(.PX_W(PX_W), .TAG_DEPTH(4)) dut (
        .clk_i      (clk),
        .nreset_i   (nreset_i),
        .mode_i     (mode_i),
        .enable_i   (enable_i),
        .flush_i    (flush_i),
        .bus        (bus.slave),
        .overflow_o (overflow_o),
        .spurious_o (spurious_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; one-cycle strobes drop back to 0 just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.s0_rdy_i = 1'b0;
        bus.s1_rdy_i = 1'b0;
        bus.dp_rdy_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic offer(input int src, input logic [PX_W-1:0] px);
        if (src == 0) begin
            bus.s0_px_i = px; bus.s0_rdy_i = 1'b1;
        end else begin
            bus.s1_px_i = px; bus.s1_rdy_i = 1'b1;
        end
    endtask

    task automatic dp_return(input logic [PX_W-1:0] px);
        bus.dp_px_i  = px;
        bus.dp_rdy_i = 1'b1;
    endtask

    task automatic apply_reset(input logic [1:0] m);
        nreset_i = 1'b0;
        mode_i   = m;
        enable_i = 1'b1;
        tick();
        tick();
        nreset_i = 1'b1;
    endtask

    logic [PX_W-1:0] exp_q[$];
    logic [PX_W-1:0] ret_q[$];
    int              src_q[$];
    int              grants;

    initial begin
        bus.s0_px_i = '0; bus.s0_rdy_i = 1'b0;
        bus.s1_px_i = '0; bus.s1_rdy_i = 1'b0;
        bus.dp_px_i = '0; bus.dp_rdy_i = 1'b0;

        // Reset state
        tick();
        check("rst_dp_rdy", bus.dp_rdy_o, 0);
        check("rst_dp_px", bus.dp_px_o, 0);
        check("rst_s0_rdy", bus.s0_rdy_o, 0);
        check("rst_s1_rdy", bus.s1_rdy_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_spurious", spurious_o, 0);
        check("rst_busy", busy_o, 0);

        // Mode 00 single pixel round trip
        apply_reset(ARB_MODE_REQ0);
        offer(0, 24'h123456);
        tick();
        check("m0_lat1_dp_rdy", bus.dp_rdy_o, 0);
        check("m0_busy_held", busy_o, 1);
        tick();
        check("m0_lat2_dp_rdy", bus.dp_rdy_o, 1);
        check("m0_dp_px", bus.dp_px_o, 24'h123456);
        tick();
        check("m0_dp_rdy_pulse", bus.dp_rdy_o, 0);
        check("m0_busy_tag", busy_o, 1);
        dp_return(24'hABCDEF);
        tick();
        check("m0_s0_rdy", bus.s0_rdy_o, 1);
        check("m0_s0_px", bus.s0_px_o, 24'hABCDEF);
        check("m0_s1_rdy", bus.s1_rdy_o, 0);
        tick();
        check("m0_s0_rdy_pulse", bus.s0_rdy_o, 0);
        check("m0_s0_px_hold", bus.s0_px_o, 24'hABCDEF);
        check("m0_busy_idle", busy_o, 0);

        // Mode 10 round robin, three rounds of simultaneous strobes
        apply_reset(ARB_MODE_RR);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(24'h11); src_q.push_back(0);
            exp_q.push_back(24'h22); src_q.push_back(1);
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc % 4 == 0 && cyc < 12) begin
                offer(0, 24'h11);
                offer(1, 24'h22);
            end
            tick();
            if (bus.s0_rdy_o || bus.s1_rdy_o) begin
                check("rr_ret_src", {31'd0, bus.s1_rdy_o}, (src_q.size() > 0) ? src_q[0] : 99);
                check("rr_ret_px", bus.s1_rdy_o ? bus.s1_px_o : bus.s0_px_o,
                      (ret_q.size() > 0) ? ret_q[0] : 24'hDEAD00);
                if (src_q.size() > 0) void'(src_q.pop_front());
                if (ret_q.size() > 0) void'(ret_q.pop_front());
            end
            if (bus.dp_rdy_o) begin
                check("rr_dp_px", bus.dp_px_o, (exp_q.size() > 0) ? exp_q[0] : 24'hDEAD01);
                if (exp_q.size() > 0) begin
                    ret_q.push_back(exp_q[0] + 24'h1000);
                    dp_return(exp_q[0] + 24'h1000);
                    void'(exp_q.pop_front());
                end
            end
        end
        check("rr_all_issued", exp_q.size(), 0);
        check("rr_all_returned", src_q.size(), 0);

        // Mode 11 fixed priority and overflow on req1
        apply_reset(ARB_MODE_PRIO);
        offer(0, 24'h31);
        offer(1, 24'h41);
        tick();
        check("pr_ovf_none", overflow_o, 0);
        offer(0, 24'h32);
        tick();
        check("pr_g1_px", bus.dp_px_o, 24'h31);
        check("pr_ovf_refill", overflow_o, 0);
        offer(1, 24'h42);
        tick();
        check("pr_g2_rdy", bus.dp_rdy_o, 1);
        check("pr_g2_px", bus.dp_px_o, 24'h32);
        check("pr_ovf_req1", overflow_o, 2'b10);
        tick();
        check("pr_g3_rdy", bus.dp_rdy_o, 1);
        check("pr_g3_px", bus.dp_px_o, 24'h41);
        tick();
        check("pr_idle_rdy", bus.dp_rdy_o, 0);

        // Mode 10 backpressure: 6 offered, 4 granted, then one pop releases one more
        apply_reset(ARB_MODE_RR);
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 2 || c == 4) begin
                offer(0, 24'hA0 + 24'(c / 2));
                offer(1, 24'hB0 + 24'(c / 2));
            end
            tick();
            if (bus.dp_rdy_o) grants++;
        end
        check("bp_grants", grants, 4);
        check("bp_busy", busy_o, 1);
        check("bp_last_px", bus.dp_px_o, 24'hB1);
        dp_return(24'h777);
        tick();
        check("bp_pop_no_grant", bus.dp_rdy_o, 0);
        check("bp_pop_s0_rdy", bus.s0_rdy_o, 1);
        check("bp_pop_s0_px", bus.s0_px_o, 24'h777);
        tick();
        check("bp_regrant_rdy", bus.dp_rdy_o, 1);
        check("bp_regrant_px", bus.dp_px_o, 24'hA2);

        // Spurious return, then flush with 2 held + 3 tags
        apply_reset(ARB_MODE_REQ0);
        dp_return(24'h5A);
        tick();
        check("sp_flag", spurious_o, 1);
        check("sp_s0_rdy", bus.s0_rdy_o, 0);
        check("sp_s1_rdy", bus.s1_rdy_o, 0);
        offer(0, 24'hC1);
        tick();
        offer(0, 24'hC2);
        tick();
        offer(0, 24'hC3);
        tick();
        tick();
        enable_i = 1'b0;
        offer(0, 24'hD0);
        offer(1, 24'hD1);
        tick();
        check("fl_busy_before", busy_o, 1);
        flush_i = 1'b1;
        offer(0, 24'hE0);
        tick();
        check("fl_busy_after", busy_o, 0);
        check("fl_spurious_sticky", spurious_o, 1);
        check("fl_ovf_none", overflow_o, 0);

        // Asynchronous reset mid-burst, then round robin starts at req0
        apply_reset(ARB_MODE_RR);
        offer(0, 24'hF0);
        offer(1, 24'hF1);
        tick();
        tick();
        check("ar_pre_rdy", bus.dp_rdy_o, 1);
        #2;
        nreset_i = 1'b0;
        #1;
        check("ar_dp_rdy", bus.dp_rdy_o, 0);
        check("ar_dp_px", bus.dp_px_o, 0);
        check("ar_busy", busy_o, 0);
        tick();
        nreset_i = 1'b1;
        offer(0, 24'h61);
        offer(1, 24'h62);
        tick();
        tick();
        check("ar_first_rdy", bus.dp_rdy_o, 1);
        check("ar_first_px", bus.dp_px_o, 24'h61);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
